// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending stores drained to the data memory port.
// Loads share the port; a load matching a pending store word stalls until it drains.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_req,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_Address,
  input  logic [1:0]               st_byte_addr,
  input  logic [1:0]               st_sel,
  input  logic [31:0]              st_Write_data,
  input  logic                     ld_req,
  input  logic [AW-1:0]            ld_Address,
  input  logic [1:0]               ld_byte_addr,
  input  logic [1:0]               ld_sel,
  output logic                     ld_stall,
  output logic [31:0]              ld_Read_data,
  output logic                     MemWrite,
  output logic [AW-1:0]            Address,
  output logic [31:0]              Write_data,
  output logic [1:0]               sel,
  output logic [1:0]               byte_addr,
  input  logic [31:0]              Read_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    ba;
    logic [1:0]    sel;
    logic [31:0]   data;
  } ent_t;

  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          enq;
  logic          drain;
  logic          ld_go;
  logic          hit;
  logic          pend_hit;
  logic [PW-1:0] off;
  ent_t          hd;

  // An entry is live when its distance from head is below count.
  always_comb begin
    pend_hit = 1'b0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (({1'b0, off} < count_q) &&
          (ent_q[i].addr == ld_Address))
        pend_hit = 1'b1;
    end
  end

  always_comb begin
    st_ready = (count_q != CW'(DEPTH));
    enq      = st_req & st_ready & ~rst;
    hit      = ~rst & ld_req &
               (pend_hit | (enq & (st_Address == ld_Address)));
    ld_go    = ~rst & ld_req & ~hit;
    drain    = ~rst & ~ld_go & (count_q != '0);
    hd       = ent_q[head_q];
  end

  always_comb begin
    ld_stall     = hit;
    ld_Read_data = Read_data;
    MemWrite     = drain;
    Address      = ld_Address;
    sel          = ld_sel;
    byte_addr    = ld_byte_addr;
    Write_data   = '0;
    count        = count_q;
    empty        = (count_q == '0);
    if (rst) begin
      Address   = '0;
      sel       = '0;
      byte_addr = '0;
    end else if (drain) begin
      Address    = hd.addr;
      sel        = hd.sel;
      byte_addr  = hd.ba;
      Write_data = hd.data;
    end
  end

  always_comb begin
    ent_d = ent_q;
    if (enq) begin
      ent_d[tail_q] = '{addr: st_Address, ba: st_byte_addr,
                        sel: st_sel, data: st_Write_data};
    end
    head_d  = head_q + PW'(drain);
    tail_d  = tail_q + PW'(enq);
    count_d = count_q + CW'(enq) - CW'(drain);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset; liveness comes from head/count.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic
// checked against a queue-and-golden-memory reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 30;

  logic          clk;
  logic          rst;
  logic          st_req;
  logic          st_ready;
  logic [AW-1:0] st_Address;
  logic [1:0]    st_byte_addr;
  logic [1:0]    st_sel;
  logic [31:0]   st_Write_data;
  logic          ld_req;
  logic [AW-1:0] ld_Address;
  logic [1:0]    ld_byte_addr;
  logic [1:0]    ld_sel;
  logic          ld_stall;
  logic [31:0]   ld_Read_data;
  logic          MemWrite;
  logic [AW-1:0] Address;
  logic [31:0]   Write_data;
  logic [1:0]    sel;
  logic [1:0]    byte_addr;
  logic [31:0]   Read_data;
  logic [2:0]    count;
  logic          empty;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .st_req(st_req), .st_ready(st_ready),
    .st_Address(st_Address), .st_byte_addr(st_byte_addr),
    .st_sel(st_sel), .st_Write_data(st_Write_data),
    .ld_req(ld_req), .ld_Address(ld_Address),
    .ld_byte_addr(ld_byte_addr), .ld_sel(ld_sel),
    .ld_stall(ld_stall), .ld_Read_data(ld_Read_data),
    .MemWrite(MemWrite), .Address(Address),
    .Write_data(Write_data), .sel(sel), .byte_addr(byte_addr),
    .Read_data(Read_data), .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'hA5C3_0000 ^ (32'(i) * 32'h0101_1357);
  endfunction

  // Big-endian lanes: byte offset 0 is bits [31:24]; loads sign-extend.
  function automatic logic [31:0] rd_fn(input logic [31:0] w,
                                        input logic [1:0] s,
                                        input logic [1:0] b);
    logic [15:0] h;
    logic [7:0]  y;
    h = b[1] ? w[15:0] : w[31:16];
    y = w[8*(3-int'(b)) +: 8];
    case (s)
      2'b00:   return w;
      2'b01:   return {{16{h[15]}}, h};
      2'b10:   return {{24{y[7]}}, y};
      default: return {31'b0, w[0]};
    endcase
  endfunction

  function automatic logic [31:0] wr_fn(input logic [31:0] w,
                                        input logic [1:0] s,
                                        input logic [1:0] b,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (s)
      2'b00: r = d;
      2'b01: if (b[1]) r[15:0] = d[15:0];
             else r[31:16] = d[15:0];
      2'b10: r[8*(3-int'(b)) +: 8] = d[7:0];
      default: r[0] = d[0];
    endcase
    return r;
  endfunction

  logic [31:0] memarr [16];
  logic [31:0] gold   [16];
  logic        mem_load;
  logic [35:0] wlog [$];

  always_comb Read_data = rd_fn(memarr[Address[3:0]], sel, byte_addr);

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) memarr[i] <= init_val(i);
    end else if (MemWrite) begin
      memarr[Address[3:0]] <= wr_fn(memarr[Address[3:0]], sel,
                                    byte_addr, Write_data);
      wlog.push_back({Address[3:0], Write_data});
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [1:0]    ba;
    logic [1:0]    s;
    logic [31:0]   d;
  } st_t;

  st_t pend [$];
  st_t sq   [$];
  logic acc;
  logic m_hit;

  function automatic st_t mk(input int a, input int s, input int b,
                             input logic [31:0] d);
    st_t e;
    e.a  = AW'(a);
    e.s  = 2'(s);
    e.ba = 2'(b);
    e.d  = d;
    return e;
  endfunction

  // One cycle: compare against the model, then advance it at the edge.
  task automatic step();
    logic m_ready, m_enq, m_ld, m_dr;
    #1;
    m_ready = pend.size() < DEPTH;
    m_enq   = st_req && m_ready;
    m_hit   = 1'b0;
    if (ld_req) begin
      foreach (pend[i]) if (pend[i].a == ld_Address) m_hit = 1'b1;
      if (m_enq && st_Address == ld_Address) m_hit = 1'b1;
    end
    m_ld = ld_req && !m_hit;
    m_dr = !m_ld && pend.size() > 0;
    chk("st_ready", 32'(st_ready), 32'(m_ready));
    chk("ld_stall", 32'(ld_stall), 32'(m_hit));
    chk("memwrite", 32'(MemWrite), 32'(m_dr));
    chk("count", 32'(count), 32'(pend.size()));
    chk("empty", 32'(empty), 32'(pend.size() == 0));
    if (m_dr) begin
      chk("wr_addr", 32'(Address), 32'(pend[0].a));
      chk("wr_data", Write_data, pend[0].d);
      chk("wr_sel", 32'(sel), 32'(pend[0].s));
      chk("wr_ba", 32'(byte_addr), 32'(pend[0].ba));
    end else if (m_ld) begin
      chk("ld_addr", 32'(Address), 32'(ld_Address));
      chk("ld_sel", 32'(sel), 32'(ld_sel));
      chk("ld_data", ld_Read_data,
          rd_fn(gold[ld_Address[3:0]], ld_sel, ld_byte_addr));
    end else begin
      chk("idle_wd", Write_data, 32'h0);
    end
    @(posedge clk);
    if (m_dr) void'(pend.pop_front());
    if (m_enq) begin
      pend.push_back(mk(int'(st_Address), int'(st_sel),
                        int'(st_byte_addr), st_Write_data));
      gold[st_Address[3:0]] = wr_fn(gold[st_Address[3:0]], st_sel,
                                    st_byte_addr, st_Write_data);
    end
    acc = m_enq;
    @(negedge clk);
  endtask

  task automatic drive_st(input int n);
    for (int k = 0; k < n; k++) begin
      if (sq.size() > 0) begin
        st_req        = 1'b1;
        st_Address    = sq[0].a;
        st_sel        = sq[0].s;
        st_byte_addr  = sq[0].ba;
        st_Write_data = sq[0].d;
      end else begin
        st_req = 1'b0;
      end
      step();
      if (acc) void'(sq.pop_front());
    end
    st_req = 1'b0;
  endtask

  task automatic send_all();
    int n = 0;
    while (sq.size() > 0 && n < 40) begin
      drive_st(1);
      n++;
    end
    if (sq.size() > 0) begin
      chk("send_tmo", 32'(sq.size()), 32'h0);
      sq.delete();
    end
  endtask

  task automatic flush();
    int n = 0;
    st_req = 1'b0;
    ld_req = 1'b0;
    while (pend.size() > 0 && n < 20) begin
      step();
      n++;
    end
    if (pend.size() > 0) chk("flush_tmo", 32'(pend.size()), 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=running want=done");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_load = 1'b1;
    acc = 1'b0;
    m_hit = 1'b0;
    st_req = 1'b1;
    st_Address = AW'(3);
    st_byte_addr = 2'd0;
    st_sel = 2'd0;
    st_Write_data = 32'h0;
    ld_req = 1'b1;
    ld_Address = AW'(3);
    ld_byte_addr = 2'd1;
    ld_sel = 2'd1;
    for (int i = 0; i < 16; i++) gold[i] = init_val(i);
    @(negedge clk);
    mem_load = 1'b0;
    #1;
    chk("rst_mw", 32'(MemWrite), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_ready", 32'(st_ready), 32'h1);
    chk("rst_stall", 32'(ld_stall), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_addr", 32'(Address), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_wd", Write_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    st_req = 1'b0;
    ld_req = 1'b0;

    // Reset in the middle of a drain
    sq.push_back(mk(1, 0, 0, 32'h1111_0001));
    sq.push_back(mk(2, 0, 0, 32'h2222_0002));
    sq.push_back(mk(3, 0, 0, 32'h3333_0003));
    drive_st(3);
    #1;
    chk("mid_mw", 32'(MemWrite), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_mw", 32'(MemWrite), 32'h0);
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    pend.delete();
    gold = memarr;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wlog.delete();
    for (int k = 0; k < 3; k++) step();
    chk("post_rst_wr", 32'(wlog.size()), 32'h0);

    // Full and backpressure behind a non-matching load
    ld_req = 1'b1;
    ld_Address = AW'(15);
    ld_sel = 2'd0;
    ld_byte_addr = 2'd0;
    for (int k = 0; k < 5; k++)
      sq.push_back(mk(8 + k, 0, 0, 32'hF000_0000 + 32'(k)));
    drive_st(7);
    chk("full_cnt", 32'(count), 32'h4);
    chk("full_rdy", 32'(st_ready), 32'h0);
    ld_req = 1'b0;
    wlog.delete();
    send_all();
    flush();
    chk("full_nwr", 32'(wlog.size()), 32'h5);
    for (int k = 0; k < 5 && k < wlog.size(); k++)
      chk("full_ord", wlog[k][31:0], 32'hF000_0000 + 32'(k));

    // Address hazard
    sq.push_back(mk(5, 0, 0, 32'h1234_5678));
    drive_st(1);
    ld_req = 1'b1;
    ld_Address = AW'(5);
    ld_sel = 2'd0;
    ld_byte_addr = 2'd0;
    #1;
    chk("hz_stall", 32'(ld_stall), 32'h1);
    chk("hz_mw", 32'(MemWrite), 32'h1);
    chk("hz_addr", 32'(Address), 32'h5);
    step();
    #1;
    chk("hz_stall0", 32'(ld_stall), 32'h0);
    chk("hz_data", ld_Read_data, 32'h1234_5678);
    step();
    ld_req = 1'b0;

    // Byte lane passthrough
    sq.push_back(mk(2, 2, 1, 32'h0000_00AB));
    drive_st(1);
    #1;
    chk("b_mw", 32'(MemWrite), 32'h1);
    chk("b_sel", 32'(sel), 32'h2);
    chk("b_ba", 32'(byte_addr), 32'h1);
    chk("b_wd", 32'(Write_data[7:0]), 32'hAB);
    step();
    step();
    ld_req = 1'b1;
    ld_Address = AW'(2);
    ld_sel = 2'd2;
    ld_byte_addr = 2'd1;
    #1;
    chk("lb_data", ld_Read_data, 32'hFFFF_FFAB);
    step();
    ld_req = 1'b0;

    // Simultaneous enqueue and drain at count 2
    ld_req = 1'b1;
    ld_Address = AW'(14);
    sq.push_back(mk(0, 0, 0, 32'hC0DE_0000));
    sq.push_back(mk(1, 0, 0, 32'hC0DE_0001));
    drive_st(2);
    ld_req = 1'b0;
    for (int k = 0; k < 16; k++)
      sq.push_back(mk(k % 8, 0, 0, 32'hBEEF_0000 + 32'(k)));
    wlog.delete();
    for (int k = 0; k < 16; k++) begin
      drive_st(1);
      chk("sim_cnt", 32'(count), 32'h2);
    end
    flush();
    chk("sim_nwr", 32'(wlog.size()), 32'd18);

    // Non-matching load holds the port
    ld_req = 1'b1;
    ld_Address = AW'(9);
    sq.push_back(mk(7, 0, 0, 32'h7777_0001));
    sq.push_back(mk(7, 0, 0, 32'h7777_0002));
    drive_st(2);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("nm_mw", 32'(MemWrite), 32'h0);
      chk("nm_stall", 32'(ld_stall), 32'h0);
      chk("nm_cnt", 32'(count), 32'h2);
      step();
    end
    flush();
    chk("nm_done", 32'(count), 32'h0);

    // Random traffic
    st_req = 1'b0;
    ld_req = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!st_req || acc) begin
        st_req        = 1'($urandom % 2);
        st_Address    = AW'($urandom % 8);
        st_sel        = 2'($urandom % 3);
        st_byte_addr  = 2'($urandom % 4);
        st_Write_data = $urandom;
      end
      if (!ld_req || !m_hit) begin
        ld_req       = 1'($urandom % 3 == 0);
        ld_Address   = AW'($urandom % 8);
        ld_sel       = 2'($urandom % 3);
        ld_byte_addr = 2'($urandom % 4);
      end
      step();
    end
    flush();
    for (int i = 0; i < 16; i++)
      chk("final_mem", memarr[i], gold[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Store buffer between the MEM-stage address/data generation and the data memory, which has a word-addressed array, big-endian byte lanes and a sel-encoded access size.
- Accepts CPU stores into a small FIFO and retires one per cycle to the memory write port, so the pipeline does not wait on stores.
- Loads share the memory port with the drain. A load whose word address matches a pending store stalls until that store has drained. No forwarding.

Parameters:
DEPTH, 4, number of store entries (power of two, >=2)
AW, 30, word-address width (Address[31:2])

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
st_req  in  1  store request from MEM stage
st_ready  out  1  store accepted this cycle (combinational: count<DEPTH)
st_Address  in  AW  store word address
st_byte_addr  in  2  store byte offset
st_sel  in  2  size: 00 word, 01 half, 10 byte, 11 bit
st_Write_data  in  32  store data, right-aligned
ld_req  in  1  load request from MEM stage
ld_Address  in  AW  load word address
ld_byte_addr  in  2  load byte offset
ld_sel  in  2  load size, same encoding
ld_stall  out  1  load blocked by address hazard; hold request
ld_Read_data  out  32  load result, valid when ld_req & !ld_stall
MemWrite  out  1  memory write enable
Address  out  AW  memory word address
Write_data  out  32  memory write data
sel  out  2  memory access size
byte_addr  out  2  memory byte offset
Read_data  in  32  combinational memory read result
count  out  $clog2(DEPTH)+1  occupied entries
empty  out  1  count==0

Behaviour:
- Storage: DEPTH entries of {Address, byte_addr, sel, Write_data}, plus head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- Reset (async, any time):
  - head=tail=count=0; all pending stores are discarded.
  - Outputs while rst is high: MemWrite=0, empty=1, st_ready=1, ld_stall=0. Address, Write_data, sel and byte_addr are 0.
- Enqueue: st_req & st_ready writes the entry at tail on the clock edge; tail increments.
- Hazard: hit = ld_req & (some valid entry has Address==ld_Address, OR st_req & st_ready & st_Address==ld_Address).
  - Compares the full word address only; sel and byte_addr are ignored, so the check is conservative.
  - ld_stall = hit.
- Port arbitration, combinational, one owner per cycle:
  - ld_req & !hit: the load owns the port. Address/sel/byte_addr come from ld_*; MemWrite=0; ld_Read_data=Read_data; no drain.
  - Otherwise, if count>0: drain the head. MemWrite=1; Address/sel/byte_addr/Write_data come from the head; the memory writes at the edge; head increments and the entry is freed at the same edge.
  - Otherwise idle: MemWrite=0. Address/sel/byte_addr come from ld_* (do not care); Write_data=0.
- A store enqueued in cycle N can drain no earlier than cycle N+1 (no bypass into the write port). Minimum store-to-memory latency is 1 cycle after acceptance.
- count update:
  - +1 on enqueue only; -1 on drain only; unchanged on simultaneous enqueue and drain.
  - When full, a drain in the same cycle does not raise st_ready; st_ready depends on the registered count only.
- Full (count==DEPTH): st_ready=0. The upstream holds st_req and the store fields stable until accepted.
- A stalled load repeats each cycle; the drain runs oldest-first until no matching entry remains. The load is then serviced in that cycle, combinationally.
- ld_Read_data is do-not-care when ld_req=0 or ld_stall=1; drive Read_data through regardless.
- Ordering: stores reach memory in acceptance order. Stores to the same word are never merged or reordered.

Test Plan:
- Reset mid-drain: enqueue 3 stores, assert rst while MemWrite=1. Required: MemWrite=0, count=0 and empty=1 immediately (asynchronous); no further writes after release.
- Full/backpressure, DEPTH=4 with ld_req held high to a non-matching address:
  - 4 stores enqueue, count=4, st_ready=0.
  - A 5th store is held until ld_req drops.
  - Memory then receives all 5 stores in order.
- Hazard: store word 0x12345678 (sel=00) to Address 5, then the next cycle ld_req Address 5 sel=00. Required: ld_stall=1 for 1 cycle while MemWrite=1 and Address=5; the following cycle ld_stall=0 and ld_Read_data=0x12345678.
- Byte-lane passthrough: store sel=10, byte_addr=01, data 0xAB to Address 2. Required: drain cycle shows sel=10, byte_addr=01, Write_data[7:0]=0xAB; a later lb load from the same location returns 0xFFFFFFAB.
- Simultaneous enqueue and drain at count=2: count stays 2, tail and head both advance. Run 16 cycles of alternating traffic and check ordering against a scoreboard.
- Non-matching load priority: with 2 stores pending to Address 7, ld_req to Address 9 for 3 cycles. Required: ld_stall=0, MemWrite=0 for those 3 cycles, count stays 2; draining resumes when ld_req drops.
